instr_encoder: RTL and testbench

- RV32I instruction encoder: packs decoded fields (class, funct3, funct7 bit 30, rd, rs1, rs2, full 32-bit immediate in the same form the ID stage produces as Imm/offset) into 32-bit instruction words.
- Feeds the instruction-memory loader and the self-check bench: encoder output re-decoded by ID must return the same fields.
- Two-stage valid/ready pipeline with a running write address.

---
 rtl/instr_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction encoder with a two-stage valid/ready pipeline.
//   S1 registers the raw decoded fields, S2 encodes them and registers the
//   32-bit word together with the byte address it belongs to.
//
// Optional build macro: INSTR_ENC_RANGE_CHK_EN
//   When defined, S2 checks that the immediate is representable in the
//   chosen format. An out-of-range immediate is replaced by a NOP with
//   out_err set. When undefined, immediates are truncated to the encoded bits.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync pipeline clear + address rewind)
//   in_valid/in_ready + in_class, in_funct3, in_funct6_7, in_rd, in_rs1,
//   in_rs2, in_imm : input descriptor channel
//   out_valid/out_ready + out_instr, out_addr, out_err : encoded word channel
module instr_encoder #(
  parameter int unsigned          ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct6_7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_I     = 4'd1,
    CLS_LW    = 4'd2,
    CLS_SW    = 4'd3,
    CLS_SB    = 4'd4,
    CLS_LUI   = 4'd5,
    CLS_AUIPC = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_JALR  = 4'd8
  } cls_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // S1 state
  logic        s1_valid_q, s1_valid_d;
  logic [3:0]  s1_class_q, s1_class_d;
  logic [2:0]  s1_f3_q, s1_f3_d;
  logic        s1_f67_q, s1_f67_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [31:0] s1_imm_q, s1_imm_d;

  // S2 state
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic              out_err_q, out_err_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  logic        s2_adv, s1_adv, accept, emit;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        is_shift;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid_q && out_ready;
  assign is_shift = (s1_f3_q == 3'd1) || (s1_f3_q == 3'd5);

  // Field packing for the word sitting in S1
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (s1_class_q)
      CLS_R:     enc_instr = {1'b0, s1_f67_q, 5'b0, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0110011};
      CLS_I:
        if (is_shift)
          enc_instr = {1'b0, s1_f67_q, 5'b0, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0010011};
        else
          enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0010011};
      CLS_LW:    enc_instr = {s1_imm_q[11:0], s1_rs1_q, 3'b010, s1_rd_q, 7'b0000011};
      CLS_JALR:  enc_instr = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, 7'b1100111};
      CLS_SW:    enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, 3'b010, s1_imm_q[4:0], 7'b0100011};
      CLS_SB:    enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:1], s1_imm_q[11], 7'b1100011};
      CLS_LUI:   enc_instr = {s1_imm_q[31:12], s1_rd_q, 7'b0110111};
      CLS_AUIPC: enc_instr = {s1_imm_q[31:12], s1_rd_q, 7'b0010111};
      CLS_JAL:   enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                              s1_rd_q, 7'b1101111};
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHK_EN
  logic signed [31:0] imm_s;
  logic               range_bad;
  assign imm_s = $signed(s1_imm_q);

  always_comb begin
    range_bad = 1'b0;
    case (s1_class_q)
      CLS_I:
        if (is_shift) range_bad = (s1_imm_q[31:5] != '0);
        else          range_bad = (imm_s < -2048) || (imm_s > 2047);
      CLS_LW, CLS_JALR, CLS_SW:
        range_bad = (imm_s < -2048) || (imm_s > 2047);
      CLS_SB:
        range_bad = (imm_s < -4096) || (imm_s > 4094) || s1_imm_q[0];
      CLS_JAL:
        range_bad = (imm_s < -1048576) || (imm_s > 1048574) || s1_imm_q[0];
      CLS_LUI, CLS_AUIPC:
        range_bad = (s1_imm_q[11:0] != '0);
      default: range_bad = 1'b0;
    endcase
  end
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_class_d  = s1_class_q;
    s1_f3_d     = s1_f3_q;
    s1_f67_d    = s1_f67_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_imm_d    = s1_imm_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    out_addr_d  = out_addr_q;

    // Accept takes precedence over draining so S1 can refill in the same
    // cycle it hands its word to S2.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_class_d = in_class;
      s1_f3_d    = in_funct3;
      s1_f67_d   = in_funct6_7;
      s1_rd_d    = in_rd;
      s1_rs1_d   = in_rs1;
      s1_rs2_d   = in_rs2;
      s1_imm_d   = in_imm;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = enc_instr;
        out_err_d   = enc_err;
`ifdef INSTR_ENC_RANGE_CHK_EN
        if (range_bad) begin
          out_instr_d = NOP;
          out_err_d   = 1'b1;
        end
`endif
      end
    end

    if (emit) out_addr_d = out_addr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      out_addr_q  <= BASE_ADDR;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // Payload registers carry no reset; they are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    s1_class_q <= s1_class_d;
    s1_f3_q    <= s1_f3_d;
    s1_f67_q   <= s1_f67_d;
    s1_rd_q    <= s1_rd_d;
    s1_rs1_q   <= s1_rs1_d;
    s1_rs2_q   <= s1_rs2_d;
    s1_imm_q   <= s1_imm_d;
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, in_f67;
  logic [3:0]    in_class;
  logic [2:0]    in_f3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready, out_err;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(4'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_f3), .in_funct6_7(in_f67),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f67;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } desc_t;

  typedef struct {
    logic [31:0]   instr;
    logic          err;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          sb_q[$];
  logic [AW-1:0] exp_addr;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic desc_t mk(input logic [3:0] cls, input logic [2:0] f3, input logic f67,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    desc_t d;
    d.cls = cls; d.f3 = f3; d.f67 = f67; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm = imm; d.exp_instr = ei; d.exp_err = ee;
    return d;
  endfunction

  task automatic push(input desc_t d);
    exp_t e;
    e.instr = d.exp_instr; e.err = d.exp_err; e.addr = exp_addr;
    sb_q.push_back(e);
    exp_addr = exp_addr + 4'd4;
  endtask

  task automatic drive(input desc_t d);
    in_class = d.cls; in_f3 = d.f3; in_f67 = d.f67;
    in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm;
    in_valid = 1'b1;
  endtask

  // Present d from the next falling edge and hold it until accepted.
  task automatic send(input desc_t d);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    drive(d);
    for (int c = 0; c < 50 && !acc; c++) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) push(d);
      else @(negedge clk);
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 50) begin
      @(posedge clk);
      c++;
    end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_word: got 0x%08h expected no output", out_instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_err", {31'b0, out_err}, {31'b0, e.err});
        check("out_addr", {28'b0, out_addr}, {28'b0, e.addr});
      end
    end
  end

  desc_t bp[3];
  desc_t addi5;
  logic [31:0] held;
  logic        have_held, a;
  int          idx;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_f3 = '0; in_f67 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_out_addr", {28'b0, out_addr}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk) reset = 1'b0;

    // Latency: accept at N -> out_valid at N+2
    addi5 = mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    send(addi5);
    #1 check("lat_n1_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("lat_n2_valid", {31'b0, out_valid}, 32'd1);
    drain();

    // Back-to-back stream, including the wrap from 0xC to 0x0
    send(mk(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0));   // ADD
    send(mk(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0));   // SUB
    send(mk(4'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0));   // SW f3 forced
    send(mk(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0));   // BEQ +8
    send(mk(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF, 1'b0));  // JAL +16
    send(mk(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0)); // LUI
    send(mk(4'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 1'b0));   // SRAI
    send(mk(4'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0)); // LW -4
    send(mk(4'd8, 3'd7, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 32'h0000_8067, 1'b0));   // JALR f3 forced
    send(mk(4'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1097, 1'b0)); // AUIPC
    send(mk(4'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_9CE3, 1'b0)); // BNE -8
    send(mk(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 32'h0000_0013, 1'b1));  // illegal
`ifdef INSTR_ENC_RANGE_CHK_EN
    send(mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1));
`else
    send(mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b0));
`endif
    idle();
    drain();

    // Backpressure: 5 cycles of out_ready=0 with 3 descriptors offered
    bp[0] = mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    bp[1] = mk(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    bp[2] = mk(4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
    idx = 0; have_held = 1'b0; held = '0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      drive(bp[idx]);
      #1 a = in_ready;
      if (c == 4) begin
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_accepted", idx, 32'd2);
      end
      if (!out_ready && out_valid) begin
        if (have_held) check("bp_stable", out_instr, held);
        held = out_instr; have_held = 1'b1;
      end
      @(posedge clk);
      if (a) begin
        push(bp[idx]);
        idx++;
      end
    end
    check("bp_all_accepted", idx, 32'd3);
    idle();
    drain();

    // Flush with both stages full while out_addr is 0xC
    while (exp_addr != 4'hC) send(addi5);
    idle();
    drain();
    @(negedge clk) out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_flush_valid", {31'b0, out_valid}, 32'd1);
    check("pre_flush_addr", {28'b0, out_addr}, 32'hC);
    flush = 1'b1;
    @(posedge clk);
    sb_q.delete();
    exp_addr = 4'h0;
    #1;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_out_addr", {28'b0, out_addr}, 32'd0);
    check("flush_out_instr", out_instr, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("flush_s1_dropped", {31'b0, out_valid}, 32'd0);

    // Four words after flush wrap out_addr back to 0
    for (int k = 0; k < 4; k++) send(bp[k % 3]);
    idle();
    drain();
    @(negedge clk);
    check("wrap_addr", {28'b0, out_addr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
